// File: rtl/lieat_exu_bru_if.sv
// Branch-issue channel between the EX stage and the branch resolver.
// Carries the operands, the IFU prediction and the fetch epoch tag, with a valid/ready handshake.
interface lieat_exu_bru_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_src1;
  logic [XLEN-1:0] br_src2;
  logic            br_prdt_taken;
  logic            br_epoch;

  modport master (
    output br_valid, br_pc, br_imm, br_funct3, br_src1, br_src2, br_prdt_taken, br_epoch,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_pc, br_imm, br_funct3, br_src1, br_src2, br_prdt_taken, br_epoch,
    output br_ready
  );
endinterface

// File: rtl/lieat_exu_bru.sv
// EXU branch resolver: evaluates bxx conditions, trains the IFU predictor and issues
// a one-cycle redirect on misprediction. An epoch bit drops wrong-path branches.
module lieat_exu_bru #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  lieat_exu_bru_if.slave      br,
  input  logic                ext_flush,
  output logic                cur_epoch,
  output logic                flush_req,
  output logic [XLEN-1:0]     flush_pc,
  output logic                bxx_callback_en,
  output logic                bxx_callback_result,
  output logic [4:0]          bxx_callback_index,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispred_cnt
);

  logic            taken;
  logic [XLEN-1:0] target;
  logic            accept;

  logic            r_valid;
  logic            r_taken;
  logic            r_mispred;
  logic [XLEN-1:0] r_target;
  logic [4:0]      r_index;
  logic [XLEN-1:0] flush_pc_q;
  logic            epoch_q;
  logic            out_fire;

  always_comb begin
    taken = 1'b0;
    case (br.br_funct3)
      3'b000:  taken = (br.br_src1 == br.br_src2);
      3'b001:  taken = (br.br_src1 != br.br_src2);
      3'b100:  taken = ($signed(br.br_src1) <  $signed(br.br_src2));
      3'b101:  taken = ($signed(br.br_src1) >= $signed(br.br_src2));
      3'b110:  taken = (br.br_src1 <  br.br_src2);
      3'b111:  taken = (br.br_src1 >= br.br_src2);
      default: taken = 1'b0;
    endcase
  end

  assign target = taken ? (br.br_pc + br.br_imm) : (br.br_pc + XLEN'(4));

  // A registered result is killed by an older external flush in its output cycle.
  assign out_fire  = r_valid & ~ext_flush;
  assign flush_req = out_fire & r_mispred;

  assign br.br_ready = ~(flush_req | ext_flush);
  assign accept      = br.br_valid & br.br_ready & (br.br_epoch == epoch_q) & ~ext_flush;

  assign bxx_callback_en     = out_fire;
  assign bxx_callback_result = r_taken;
  assign bxx_callback_index  = r_index;
  assign flush_pc            = flush_req ? r_target : flush_pc_q;
  assign cur_epoch           = epoch_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_mispred <= 1'b0;
      r_target  <= '0;
      r_index   <= '0;
    end else begin
      r_valid <= accept;
      if (accept) begin
        r_taken   <= taken;
        r_mispred <= (taken != br.br_prdt_taken);
        r_target  <= target;
        r_index   <= br.br_pc[6:2];
      end
    end
  end

  // flush_req already excludes ext_flush, so a coincident pair toggles the epoch once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      epoch_q     <= 1'b0;
      flush_pc_q  <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (flush_req | ext_flush) epoch_q <= ~epoch_q;
      if (flush_req) begin
        flush_pc_q  <= r_target;
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
      if (out_fire) branch_cnt <= branch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lieat_exu_bru.sv
// Scoreboard bench for lieat_exu_bru: stimulus pushes expected callbacks, a negedge
// monitor pops and compares them; directed checks cover epoch, ready and counters.
module tb_lieat_exu_bru;

  typedef struct packed {
    logic        res;
    logic [4:0]  idx;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        ext_flush;
  logic        cur_epoch;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        bxx_callback_en;
  logic        bxx_callback_result;
  logic [4:0]  bxx_callback_index;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  lieat_exu_bru_if #(.XLEN(32)) bif ();

  lieat_exu_bru #(.XLEN(32), .CNT_W(32)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .br                  (bif.slave),
    .ext_flush           (ext_flush),
    .cur_epoch           (cur_epoch),
    .flush_req           (flush_req),
    .flush_pc            (flush_pc),
    .bxx_callback_en     (bxx_callback_en),
    .bxx_callback_result (bxx_callback_result),
    .bxx_callback_index  (bxx_callback_index),
    .branch_cnt          (branch_cnt),
    .mispred_cnt         (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bxx_callback_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_callback", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cb_result", 32'(bxx_callback_result), 32'(e.res));
          chk("cb_index", 32'(bxx_callback_index), 32'(e.idx));
          chk("flush_req", 32'(flush_req), 32'(e.fl));
          if (e.fl) chk("flush_pc", flush_pc, e.fpc);
        end
      end else if (flush_req) begin
        chk("flush_without_callback", 32'(flush_req), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                       input logic [31:0] s1, input logic [31:0] s2, input logic prdt,
                       input logic ep);
    bif.br_valid      = 1'b1;
    bif.br_pc         = pc;
    bif.br_imm        = imm;
    bif.br_funct3     = f3;
    bif.br_src1       = s1;
    bif.br_src2       = s2;
    bif.br_prdt_taken = prdt;
    bif.br_epoch      = ep;
  endtask

  // Offers one branch for a single cycle; returns just after the edge that accepts it (cycle N+1).
  task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                       input logic [31:0] s1, input logic [31:0] s2, input logic prdt,
                       input logic ep, input logic push, input logic res, input logic [4:0] idx,
                       input logic fl, input logic [31:0] fpc);
    exp_t e;
    @(negedge clk);
    drive(pc, imm, f3, s1, s2, prdt, ep);
    if (push) begin
      e.res = res; e.idx = idx; e.fl = fl; e.fpc = fpc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bif.br_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    ext_flush = 1'b0;
    bif.br_valid = 1'b0;
    drive(32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
    bif.br_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cur_epoch", 32'(cur_epoch), 32'd0);
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_cb_en", 32'(bxx_callback_en), 32'd0);
    chk("rst_cb_result", 32'(bxx_callback_result), 32'd0);
    chk("rst_cb_index", 32'(bxx_callback_index), 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_br_ready", 32'(bif.br_ready), 32'd1);

    // BEQ correctly predicted taken
    issue(32'h80000010, 32'h20, 3'b000, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0);
    chk("beq_flush_req", 32'(flush_req), 32'd0);
    next_cycle();
    chk("beq_branch_cnt", branch_cnt, 32'd1);
    chk("beq_epoch", 32'(cur_epoch), 32'd0);

    // BLT signed -1 < 1, predicted not taken: redirect to pc-8
    issue(32'h80000000, 32'hFFFFFFF8, 3'b100, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0,
          1'b1, 1'b1, 5'd0, 1'b1, 32'h7FFFFFF8);
    chk("blt_br_ready_n1", 32'(bif.br_ready), 32'd0);
    chk("blt_epoch_n1", 32'(cur_epoch), 32'd0);
    next_cycle();
    chk("blt_epoch_n2", 32'(cur_epoch), 32'd1);
    chk("blt_mispred_cnt", mispred_cnt, 32'd1);
    chk("blt_flush_pc_hold", flush_pc, 32'h7FFFFFF8);
    chk("blt_br_ready_n2", 32'(bif.br_ready), 32'd1);

    // BLTU unsigned 0xFFFFFFFF < 1 is false, predicted taken: redirect to pc+4
    issue(32'h100, 32'hFFFFFFF8, 3'b110, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1,
          1'b1, 1'b0, 5'd0, 1'b1, 32'h104);
    next_cycle();
    chk("bltu_epoch", 32'(cur_epoch), 32'd0);
    chk("bltu_mispred_cnt", mispred_cnt, 32'd2);

    // BNE mispredict, then a stale epoch-0 branch in N+2 that must be dropped
    issue(32'h200, 32'h40, 3'b001, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 32'h240);
    @(posedge clk);
    issue(32'h280, 32'h10, 3'b000, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("stale_cb_en", 32'(bxx_callback_en), 32'd0);
    next_cycle();
    chk("stale_branch_cnt", branch_cnt, 32'd4);
    chk("stale_mispred_cnt", mispred_cnt, 32'd3);
    chk("stale_epoch", 32'(cur_epoch), 32'd1);

    // epoch-1 BGE 3>=3 predicted taken, then illegal funct3 010 predicted taken
    issue(32'h30C, 32'h10, 3'b101, 32'd3, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0);
    issue(32'h400, 32'h80, 3'b010, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 32'h404);
    next_cycle();
    chk("illegal_branch_cnt", branch_cnt, 32'd6);
    chk("illegal_mispred_cnt", mispred_cnt, 32'd4);
    chk("illegal_epoch", 32'(cur_epoch), 32'd0);

    // Mispredict killed by ext_flush in its output cycle
    issue(32'h500, 32'h20, 3'b000, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    ext_flush = 1'b1;
    #1;
    chk("kill_flush_req", 32'(flush_req), 32'd0);
    chk("kill_cb_en", 32'(bxx_callback_en), 32'd0);
    chk("kill_br_ready", 32'(bif.br_ready), 32'd0);
    next_cycle();
    ext_flush = 1'b0;
    chk("kill_epoch_once", 32'(cur_epoch), 32'd1);
    chk("kill_mispred_cnt", mispred_cnt, 32'd4);
    chk("kill_branch_cnt", branch_cnt, 32'd6);
    chk("kill_flush_pc_hold", flush_pc, 32'h404);

    // Fresh reset, then three back-to-back correctly predicted branches
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    @(negedge clk);
    drive(32'h1000, 32'h40, 3'b000, 32'd7, 32'd7, 1'b1, 1'b0);
    exp_q.push_back('{res: 1'b1, idx: 5'd0, fl: 1'b0, fpc: 32'h0});
    @(negedge clk);
    chk("b2b_cb0", 32'(bxx_callback_en), 32'd1);
    drive(32'h1004, 32'h40, 3'b001, 32'd1, 32'd1, 1'b0, 1'b0);
    exp_q.push_back('{res: 1'b0, idx: 5'd1, fl: 1'b0, fpc: 32'h0});
    @(negedge clk);
    chk("b2b_cb1", 32'(bxx_callback_en), 32'd1);
    drive(32'h1008, 32'h40, 3'b111, 32'd5, 32'd3, 1'b1, 1'b0);
    exp_q.push_back('{res: 1'b1, idx: 5'd2, fl: 1'b0, fpc: 32'h0});
    @(negedge clk);
    chk("b2b_cb2", 32'(bxx_callback_en), 32'd1);
    bif.br_valid = 1'b0;
    @(negedge clk);
    chk("b2b_branch_cnt", branch_cnt, 32'd3);
    chk("b2b_mispred_cnt", mispred_cnt, 32'd0);

    // Mispredicting branch pending in its output cycle when reset hits
    issue(32'h2010, 32'h20, 3'b000, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("pre_rst_cb_en", 32'(bxx_callback_en), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_cb_en", 32'(bxx_callback_en), 32'd0);
    chk("mid_rst_flush_req", 32'(flush_req), 32'd0);
    chk("mid_rst_cb_index", 32'(bxx_callback_index), 32'd0);
    chk("mid_rst_branch_cnt", branch_cnt, 32'd0);
    chk("mid_rst_mispred_cnt", mispred_cnt, 32'd0);
    chk("mid_rst_epoch", 32'(cur_epoch), 32'd0);
    chk("mid_rst_flush_pc", flush_pc, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lieat_exu_bru.md
Name: lieat_exu_bru

Overview:
- EXU-side branch resolution unit. It is the responder end of the IFU branch predictor's training and redirect interface.
- Takes conditional branches (bxx) issued with the IFU's prediction bit and evaluates the condition, then produces the predictor training callback (`bxx_callback_*`) and a one-cycle redirect (`flush_req`/`flush_pc`) on misprediction.
- An epoch bit discards wrong-path branches still in flight after a redirect.

Parameters:
- XLEN, 32, datapath/PC width
- CNT_W, 32, width of the branch and mispredict statistics counters

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- br_valid  input  1  branch operation offered by EX stage
- br_ready  output  1  resolver can accept a branch this cycle
- br_pc  input  XLEN  PC of the branch
- br_imm  input  XLEN  sign-extended B-type offset
- br_funct3  input  3  branch condition code
- br_src1  input  XLEN  rs1 operand
- br_src2  input  XLEN  rs2 operand
- br_prdt_taken  input  1  IFU prediction carried with the instruction
- br_epoch  input  1  epoch tag attached by IFU at fetch
- ext_flush  input  1  older flush from trap/commit logic, highest priority
- cur_epoch  output  1  current epoch, fed back to IFU for tagging
- flush_req  output  1  one-cycle redirect pulse to IFU
- flush_pc  output  XLEN  redirect target
- bxx_callback_en  output  1  one-cycle predictor training strobe
- bxx_callback_result  output  1  actual direction (1 = taken)
- bxx_callback_index  output  5  predictor index, equal to br_pc[6:2]
- branch_cnt  output  CNT_W  resolved-branch counter
- mispred_cnt  output  CNT_W  misprediction counter

Behaviour:
- Reset values:
  - cur_epoch=0, flush_req=0, flush_pc=0.
  - bxx_callback_en/result/index=0.
  - Both counters=0; internal result-valid register=0.
- Accept condition: `br_valid & br_ready & (br_epoch==cur_epoch) & !ext_flush`.
- Stale branch (`br_valid & br_ready` with epoch mismatch):
  - Consumed and dropped; counts nothing; produces no output.
- Condition decode on funct3:
  - 000 BEQ (==), 001 BNE (!=).
  - 100 BLT (signed <), 101 BGE (signed >=).
  - 110 BLTU (unsigned <), 111 BGEU (unsigned >=).
  - 010/011 are illegal: resolved as not-taken, still trained and counted.
- Target computation: taken = br_pc+br_imm, not-taken = br_pc+4. Both are modulo 2^XLEN, so wrap-around is ignored.
- Pipeline: one register stage.
  - A branch accepted in cycle N drives outputs in cycle N+1.
  - In N+1, `bxx_callback_en=1` with result and index.
  - branch_cnt increments by 1.
- Mispredict (actual != br_prdt_taken) in cycle N+1:
  - flush_req=1.
  - flush_pc = actual target.
  - mispred_cnt increments.
  - cur_epoch toggles, so it reads the new value from N+2 onward.
- All pulse outputs are single-cycle. `flush_pc` holds its last value when flush_req=0.
- br_ready:
  - 0 in any cycle where flush_req=1 or ext_flush=1.
  - 1 otherwise, including on the cycle immediately after a flush.
  - Back-to-back accepts are allowed when no mispredict occurs.
- ext_flush:
  - Toggles cur_epoch at the next edge.
  - Kills any registered result in the same cycle: no callback, no flush_req, no counter update for it.
  - Blocks acceptance that cycle.
  - ext_flush in the cycle a mispredict would be output: the resolver's flush_req, callback and mispred_cnt are suppressed; the epoch toggles once, not twice.
- Counters wrap at 2^CNT_W.
- Reset asserted mid-operation clears all state asynchronously; any pending result is lost.

Test Plan:
- BEQ src1=src2=5, prdt_taken=1, pc=0x80000010, imm=0x20 -> N+1:
  - callback_en=1, result=1, index=4.
  - flush_req=0; branch_cnt=1; cur_epoch unchanged.
- BLT src1=0xFFFFFFFF, src2=1, prdt_taken=0, pc=0x80000000, imm=-8 -> N+1:
  - flush_req=1, flush_pc=0x7FFFFFF8; mispred_cnt=1.
  - cur_epoch=1 from N+2; br_ready=0 in N+1.
- BLTU same operands, prdt_taken=1, pc=0x100 -> N+1: result=0, flush_req=1, flush_pc=0x104.
- Mispredict followed by a branch tagged with the old epoch 0 in N+2 -> it is dropped: no callback, counters unchanged. Next branch with epoch 1 is accepted normally.
- Mispredicting branch registered while ext_flush=1 in the output cycle:
  - flush_req=0, callback_en=0, mispred_cnt unchanged.
  - cur_epoch toggles exactly once.
- Back-to-back three correctly predicted branches, then rstn pulsed low mid-stream:
  - Callbacks appear on consecutive cycles.
  - Branch_cnt=3 before reset; all outputs and counters return to 0 immediately on reset.
